// File: rtl/gost_pkg.sv
// gost_pkg: shared Magma widths, cipher direction codes and gost_ctr state encoding
package gost_pkg;
    localparam int BLOCK_W = 64;
    localparam int KEY_W = 256;
    localparam logic ENCRYPT = 1'b0;
    localparam logic DECRYPT = 1'b1;
    typedef enum logic [2:0] {UNINIT, IDLE, START, WAIT_LO, WAIT_HI, OUT, FLUSH} ctr_state_t;
endpackage

// File: rtl/gost_ctr.sv
// gost_ctr: counter-mode front end that drives an external Magma core and XORs keystream into data words
module gost_ctr
    import gost_pkg::*;
#(
    parameter int CTR_W = 32
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  iinit,
    input  logic [63-CTR_W:0]     iiv,
    input  logic [BLOCK_W-1:0]    idata,
    input  logic                  ivalid,
    output logic                  oready,
    output logic [BLOCK_W-1:0]    odata,
    output logic                  ovalid,
    input  logic                  iready,
    output logic                  owrap,
    output logic                  ogost_start,
    output logic                  ogost_enc_dec,
    output logic [BLOCK_W-1:0]    ogost_block,
    input  logic [BLOCK_W-1:0]    igost_block,
    input  logic                  igost_done
);
    ctr_state_t state, state_nx;
    logic [63-CTR_W:0] iv;
    logic [CTR_W-1:0] ctr;
    logic [BLOCK_W-1:0] data;
    logic busy;

    assign busy = (state == START) || (state == WAIT_LO) || (state == WAIT_HI);
    assign oready = (state == IDLE) && !iinit;
    assign ovalid = (state == OUT);
    assign ogost_start = (state == START) && igost_done && !iinit;
    assign owrap = ovalid && iready && !iinit && (&ctr);
    assign ogost_enc_dec = ENCRYPT;
    assign ogost_block = {iv, ctr};

    always_comb begin
        state_nx = state;
        case (state)
            UNINIT:  state_nx = UNINIT;
            IDLE:    state_nx = ivalid ? START : IDLE;
            START:   state_nx = igost_done ? WAIT_LO : START;
            WAIT_LO: state_nx = igost_done ? WAIT_LO : WAIT_HI;
            WAIT_HI: state_nx = igost_done ? OUT : WAIT_HI;
            OUT:     state_nx = iready ? IDLE : OUT;
            FLUSH:   state_nx = igost_done ? IDLE : FLUSH;
            default: state_nx = UNINIT;
        endcase
        // an abort must let a running cipher finish before a new start is allowed
        if (iinit)
            state_nx = (busy || (state == FLUSH && !igost_done)) ? FLUSH : IDLE;
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state <= UNINIT;
            iv    <= '0;
            ctr   <= '0;
            data  <= '0;
            odata <= '0;
        end else begin
            state <= state_nx;
            if (iinit) begin
                iv  <= iiv;
                ctr <= '0;
            end else begin
                if (oready && ivalid)
                    data <= idata;
                if (state == WAIT_HI && igost_done)
                    odata <= data ^ igost_block;
                if (ovalid && iready)
                    ctr <= ctr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gost_ctr.sv
// tb_gost_ctr: directed vectors for gost_ctr against stub ciphers with programmable busy time
module tb_gost_ctr;
    logic iclk = 1'b0;
    logic irst;
    logic init [2];
    logic [31:0] iv0;
    logic [59:0] iv1;
    logic [63:0] din [2];
    logic vin [2];
    logic rdy [2];
    logic oready_w [2];
    logic [63:0] odata_w [2];
    logic ovalid_w [2];
    logic owrap_w [2];
    logic gst [2];
    logic ged [2];
    logic [63:0] gblk [2];
    logic [63:0] kblk [2];
    logic gdone [2];
    logic pend [2];
    int cnt [2];
    int lat [2];
    int tests = 0;
    int fails = 0;
    int hs1 = 0;
    int wraps = 0;
    int wrap_hs = 0;

    always #5 iclk = ~iclk;

    gost_ctr #(.CTR_W(32)) dut0 (
        .iclk(iclk), .irst(irst), .iinit(init[0]), .iiv(iv0), .idata(din[0]), .ivalid(vin[0]),
        .oready(oready_w[0]), .odata(odata_w[0]), .ovalid(ovalid_w[0]), .iready(rdy[0]),
        .owrap(owrap_w[0]), .ogost_start(gst[0]), .ogost_enc_dec(ged[0]), .ogost_block(gblk[0]),
        .igost_block(kblk[0]), .igost_done(gdone[0])
    );

    gost_ctr #(.CTR_W(4)) dut1 (
        .iclk(iclk), .irst(irst), .iinit(init[1]), .iiv(iv1), .idata(din[1]), .ivalid(vin[1]),
        .oready(oready_w[1]), .odata(odata_w[1]), .ovalid(ovalid_w[1]), .iready(rdy[1]),
        .owrap(owrap_w[1]), .ogost_start(gst[1]), .ogost_enc_dec(ged[1]), .ogost_block(gblk[1]),
        .igost_block(kblk[1]), .igost_done(gdone[1])
    );

    // stub keystream: the standard Magma vector for its counter block, a fixed mix otherwise
    function automatic logic [63:0] ks(input logic [63:0] b);
        return (b == 64'h1234567800000000) ? 64'hdc46e167aba4b365
                                           : ({b[31:0], b[63:32]} ^ 64'h0f1e2d3c4b5a6978);
    endfunction

    // stub cipher: done stays high the cycle after start, returns high lat cycles after start
    assign gdone[0] = (cnt[0] == 0);
    assign gdone[1] = (cnt[1] == 0);
    always @(posedge iclk or posedge irst) begin
        for (int d = 0; d < 2; d++) begin
            if (irst) begin
                pend[d] <= 1'b0;
                cnt[d]  <= 0;
                kblk[d] <= '0;
            end else if (pend[d]) begin
                pend[d] <= 1'b0;
                cnt[d]  <= lat[d] - 1;
            end else if (gst[d] && gdone[d]) begin
                pend[d] <= 1'b1;
                kblk[d] <= ks(gblk[d]);
            end else if (cnt[d] != 0) begin
                cnt[d] <= cnt[d] - 1;
            end
        end
    end

    always @(posedge iclk) begin
        if (ovalid_w[1] && rdy[1]) hs1 <= hs1 + 1;
        if (owrap_w[1]) begin
            wraps   <= wraps + 1;
            wrap_hs <= hs1 + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_init(input int d, input logic [59:0] v);
        @(negedge iclk);
        init[d] = 1'b1;
        if (d == 0) iv0 = v[31:0]; else iv1 = v;
        @(negedge iclk);
        init[d] = 1'b0;
    endtask

    task automatic accept(input int d, input logic [63:0] w, input string nm);
        int k;
        k = 0;
        while (!oready_w[d] && k < 200) begin
            @(negedge iclk);
            k++;
        end
        chk({nm, " ready"}, 64'(oready_w[d]), 64'd1);
        din[d] = w;
        vin[d] = 1'b1;
        @(negedge iclk);
        vin[d] = 1'b0;
        din[d] = '0;
    endtask

    task automatic xfer(input int d, input logic [63:0] w, input logic [63:0] eb,
                        input logic [63:0] eo, input int bp, input string nm);
        int k;
        logic [63:0] held;
        accept(d, w, nm);
        k = 1;
        while (!gst[d] && k < 200) begin
            @(negedge iclk);
            k++;
        end
        chk({nm, " blk"}, gblk[d], eb);
        while (!ovalid_w[d] && k < 400) begin
            @(negedge iclk);
            k++;
        end
        chk({nm, " lat"}, 64'(k), 64'(lat[d] + 3));
        held = odata_w[d];
        for (int i = 0; i < bp; i++) begin
            @(negedge iclk);
            chk({nm, " hold"}, {odata_w[d] ^ held, 61'(0), ovalid_w[d], oready_w[d], gblk[d] == eb},
                {64'd0, 61'(0), 1'b1, 1'b0, 1'b1});
        end
        chk({nm, " data"}, odata_w[d], eo);
        rdy[d] = 1'b1;
        @(negedge iclk);
        rdy[d] = 1'b0;
        chk({nm, " drop"}, 64'(ovalid_w[d]), 64'd0);
    endtask

    typedef struct {
        logic        reinit;
        logic [31:0] iv;
        logic [63:0] word;
        logic [63:0] blk;
        logic [63:0] exp;
        int          bp;
        int          l;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [5];
        int lo_cnt, ov_cnt;
        logic [63:0] w, b;
        irst = 1'b1;
        iv0 = '0;
        iv1 = '0;
        for (int d = 0; d < 2; d++) begin
            init[d] = 1'b0; din[d] = '0; vin[d] = 1'b0; rdy[d] = 1'b0; lat[d] = 4;
        end
        #12;
        chk("rst ready", 64'(oready_w[0]), 64'd0);
        chk("rst outs", {owrap_w[0], ovalid_w[0], gst[0], ged[0]}, 64'd0);
        chk("rst odata", odata_w[0], 64'd0);
        chk("rst blk", gblk[0], 64'd0);
        @(negedge iclk);
        irst = 1'b0;
        repeat (3) @(negedge iclk);
        chk("uninit ready", 64'(oready_w[0]), 64'd0);

        vt[0] = '{1'b1, 32'h12345678, 64'h92def06b3c130a59, 64'h1234567800000000, 64'h4e98110c97b7b93c, 0, 4};
        vt[1] = '{1'b1, 32'h12345678, 64'h4e98110c97b7b93c, 64'h1234567800000000, 64'h92def06b3c130a59, 0, 2};
        vt[2] = '{1'b0, 32'h12345678, 64'h0, 64'h1234567800000001, 64'h0 ^ ks(64'h1234567800000001), 10, 5};
        vt[3] = '{1'b0, 32'h12345678, 64'hffffffffffffffff, 64'h1234567800000002,
                  64'hffffffffffffffff ^ ks(64'h1234567800000002), 0, 9};
        vt[4] = '{1'b0, 32'h12345678, 64'h0123456789abcdef, 64'h1234567800000003,
                  64'h0123456789abcdef ^ ks(64'h1234567800000003), 3, 3};
        for (int i = 0; i < 5; i++) begin
            if (vt[i].reinit) do_init(0, 60'(vt[i].iv));
            lat[0] = vt[i].l;
            xfer(0, vt[i].word, vt[i].blk, vt[i].exp, vt[i].bp, $sformatf("vec%0d", i));
        end

        // 4-bit counter: 17 words, counter blocks 0..15,0 and a single wrap pulse
        do_init(1, 60'habcdef012345678);
        for (int i = 0; i < 17; i++) begin
            w = {$urandom, $urandom};
            b = {60'habcdef012345678, 4'(i)};
            xfer(1, w, b, w ^ ks(b), 0, $sformatf("wrap%0d", i));
        end
        chk("wrap count", 64'(wraps), 64'd1);
        chk("wrap at", 64'(wrap_hs), 64'd16);

        // abort while the cipher is busy
        lat[0] = 20;
        do_init(0, 60'(32'hcafef00d));
        accept(0, 64'h5555aaaa5555aaaa, "abort");
        chk("abort start", 64'(gst[0]), 64'd1);
        repeat (3) @(negedge iclk);
        init[0] = 1'b1;
        iv0 = 32'h0badbeef;
        #1;
        chk("abort ready", 64'(oready_w[0]), 64'd0);
        @(negedge iclk);
        init[0] = 1'b0;
        lo_cnt = 0;
        ov_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (!oready_w[0]) lo_cnt++;
            if (ovalid_w[0]) ov_cnt++;
            @(negedge iclk);
        end
        chk("flush len", 64'(lo_cnt), 64'd18);
        chk("flush ovalid", 64'(ov_cnt), 64'd0);
        lat[0] = 4;
        xfer(0, 64'h1, 64'h0badbeef00000000, 64'h1 ^ ks(64'h0badbeef00000000), 0, "post abort");

        // asynchronous reset between edges in WAIT_HI
        lat[0] = 6;
        do_init(0, 60'(32'h11111111));
        accept(0, 64'h2, "areset");
        repeat (3) @(negedge iclk);
        #2;
        irst = 1'b1;
        #1;
        chk("areset outs", {oready_w[0], owrap_w[0], ovalid_w[0], gst[0]}, 64'd0);
        chk("areset odata", odata_w[0], 64'd0);
        chk("areset blk", gblk[0], 64'd0);
        @(negedge iclk);
        irst = 1'b0;
        repeat (3) @(negedge iclk);
        chk("areset uninit", 64'(oready_w[0]), 64'd0);
        lat[0] = 3;
        do_init(0, 60'(32'h22222222));
        xfer(0, 64'h3, 64'h2222222200000000, 64'h3 ^ ks(64'h2222222200000000), 0, "post reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
